// File: rtl/snake_ctrl.sv
// -----------------------------------------------------------------------------
// snake_ctrl -- movement, growth and collision control for a snake game.
//
// The body is a MAX_LEN-entry X/Y shift buffer (index 0 = head) with a live
// length register. Each move_tick advances the head one cell in the pending
// direction and shifts the body behind it. Eating grows the snake and raises
// a one-cycle gen_food request. A wall hit freezes the snake until reset.
//
// Optional feature macro: SNAKE_SELF_COLLIDE_EN
//   Defined   : the head running into its own body also ends the game.
//   Undefined : only the play-area walls end the game.
//
// Ports
//   clk             system clock, rising edge
//   rst             synchronous active-high reset
//   move_tick       one-cycle pulse: advance the snake by one cell
//   btn_up/down/left/right  level direction requests (up > down > left > right)
//   food_X, food_Y  current food cell
//   c_pixel, r_pixel  column/row of the pixel being drawn
//   gen_food        one-cycle request for a new food cell
//   game_over       sticky collision flag
//   snake_prnt      current pixel is covered by a live segment
//   score           food eaten since reset, saturating at 0xFF
// -----------------------------------------------------------------------------
module snake_ctrl #(
    parameter int MAX_LEN = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       move_tick,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic [7:0] food_X,
    input  logic [7:0] food_Y,
    input  logic [7:0] c_pixel,
    input  logic [7:0] r_pixel,
    output logic       gen_food,
    output logic       game_over,
    output logic       snake_prnt,
    output logic [7:0] score
);

    // Play area, inclusive bounds.
    localparam logic [7:0] X_MIN = 8'h10;
    localparam logic [7:0] X_MAX = 8'h90;
    localparam logic [7:0] Y_MIN = 8'h0A;
    localparam logic [7:0] Y_MAX = 8'h6E;

    localparam int               LEN_W    = $clog2(MAX_LEN + 1);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_INIT = LEN_W'(3);

    typedef enum logic [1:0] {RUN, EAT, DEAD} state_t;
    typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

    state_t           state;
    state_t           state_next;
    dir_t             cur_dir;
    dir_t             pend_dir;
    dir_t             pend_next;
    dir_t             req_dir;
    dir_t             dir_after;
    logic             req_valid;
    logic [LEN_W-1:0] len;
    logic [7:0]       seg_x [MAX_LEN];
    logic [7:0]       seg_y [MAX_LEN];
    logic [7:0]       next_x;
    logic [7:0]       next_y;
    logic             wall_hit;
    logic             self_hit;
    logic             collide;
    logic             food_hit;
    logic             do_shift;
    logic             do_eat;
    logic             pix_in_area;

    function automatic dir_t opposite(input dir_t d);
        unique case (d)
            DIR_UP:   opposite = DIR_DOWN;
            DIR_DOWN: opposite = DIR_UP;
            DIR_LEFT: opposite = DIR_RIGHT;
            default:  opposite = DIR_LEFT;
        endcase
    endfunction

    // Candidate head cell for the next move; 8-bit wrap is caught by the wall test.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        next_x = seg_x[0];
        next_y = seg_y[0];
        unique case (pend_dir)
            DIR_UP:   next_y = seg_y[0] - 8'd1;
            DIR_DOWN: next_y = seg_y[0] + 8'd1;
            DIR_LEFT: next_x = seg_x[0] - 8'd1;
            default:  next_x = seg_x[0] + 8'd1;
        endcase
    end

    assign wall_hit = (next_x < X_MIN) || (next_x > X_MAX) ||
                      (next_y < Y_MIN) || (next_y > Y_MAX);
    assign food_hit = (next_x == food_X) && (next_y == food_Y);

`ifdef SNAKE_SELF_COLLIDE_EN
    // Segment len-1 vacates its cell on this very move, so only 1..len-2 count.
    always_comb begin
        self_hit = 1'b0;
        for (int i = 1; i < MAX_LEN; i++) begin
            if ((i + 2 <= int'(len)) && (seg_x[i] == next_x) && (seg_y[i] == next_y))
                self_hit = 1'b1;
        end
    end
`else
    assign self_hit = 1'b0;
`endif

    // Wall (or body) hit takes priority over eating on the same move.
    assign collide = wall_hit | self_hit;

    // FSM next state and Moore outputs.
    always_comb begin
        state_next = state;
        gen_food   = 1'b0;
        game_over  = 1'b0;
        do_shift   = 1'b0;
        do_eat     = 1'b0;
        unique case (state)
            RUN: begin
                if (move_tick) begin
                    if (collide) begin
                        state_next = DEAD;
                    end else begin
                        do_shift = 1'b1;
                        if (food_hit) begin
                            do_eat     = 1'b1;
                            state_next = EAT;
                        end
                    end
                end
            end
            EAT: begin
                // move_tick is dropped here, not deferred.
                gen_food   = 1'b1;
                state_next = RUN;
            end
            DEAD: begin
                game_over = 1'b1;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    // Direction request. The reversal test is made against the heading the
    // snake will have after this edge, so a request sampled on the same cycle
    // as a turn cannot sneak in a U-turn.
    always_comb begin
        req_valid = btn_up | btn_down | btn_left | btn_right;
        if (btn_up)        req_dir = DIR_UP;
        else if (btn_down) req_dir = DIR_DOWN;
        else if (btn_left) req_dir = DIR_LEFT;
        else               req_dir = DIR_RIGHT;
        dir_after = do_shift ? pend_dir : cur_dir;
        pend_next = pend_dir;
        if (req_valid && (req_dir != opposite(dir_after)))
            pend_next = req_dir;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; the shift loop depends on this.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            cur_dir  <= DIR_RIGHT;
            pend_dir <= DIR_RIGHT;
            len      <= LEN_INIT;
            score    <= 8'h00;
            // NOTE: the segment buffer is reset entry by entry because the
            // starting body position is visible state, not scratch storage.
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x[i] <= 8'h00;
                seg_y[i] <= 8'h00;
            end
            seg_x[0] <= 8'h30;
            seg_y[0] <= 8'h40;
            seg_x[1] <= 8'h2F;
            seg_y[1] <= 8'h40;
            seg_x[2] <= 8'h2E;
            seg_y[2] <= 8'h40;
        end else begin
            state <= state_next;
            if (state != DEAD)
                pend_dir <= pend_next;
            if (do_shift) begin
                cur_dir  <= pend_dir;
                seg_x[0] <= next_x;
                seg_y[0] <= next_y;
                for (int i = 1; i < MAX_LEN; i++) begin
                    seg_x[i] <= seg_x[i-1];
                    seg_y[i] <= seg_y[i-1];
                end
            end
            if (do_eat) begin
                if (len != LEN_MAX)
                    len <= len + LEN_W'(1);
                if (score != 8'hFF)
                    score <= score + 8'd1;
            end
        end
    end

    // Pixel coverage: only live segments, and never outside the play area.
    assign pix_in_area = (c_pixel >= X_MIN) && (c_pixel <= X_MAX) &&
                         (r_pixel >= Y_MIN) && (r_pixel <= Y_MAX);

    always_comb begin
        snake_prnt = 1'b0;
        if (pix_in_area) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                if ((i < int'(len)) && (seg_x[i] == c_pixel) && (seg_y[i] == r_pixel))
                    snake_prnt = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_snake_ctrl.sv
// -----------------------------------------------------------------------------
// tb_snake_ctrl -- self-checking bench for snake_ctrl.
//
// A reference model keeps the body as a queue of cells (front = head), plus
// score, direction and RUN/EAT/DEAD flags. Each stimulus cycle pushes the
// expected outputs for that cycle into a queue; a monitor on the falling
// edge pops and compares gen_food, game_over, score and snake_prnt.
// Honours SNAKE_SELF_COLLIDE_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_snake_ctrl;

    localparam int MAX_LEN = 16;

`ifdef SNAKE_SELF_COLLIDE_EN
    localparam int SELF_EN = 1;
`else
    localparam int SELF_EN = 0;
`endif

    // Button vectors {up, down, left, right}.
    localparam logic [3:0] B_NONE  = 4'b0000;
    localparam logic [3:0] B_UP    = 4'b1000;
    localparam logic [3:0] B_DOWN  = 4'b0100;
    localparam logic [3:0] B_LEFT  = 4'b0010;
    localparam logic [3:0] B_RIGHT = 4'b0001;

    // Model direction names.
    localparam int MU = 0;
    localparam int MD = 1;
    localparam int ML = 2;
    localparam int MR = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       move_tick;
    logic       btn_up, btn_down, btn_left, btn_right;
    logic [7:0] food_X, food_Y, c_pixel, r_pixel;
    logic       gen_food, game_over, snake_prnt;
    logic [7:0] score;

    always #5 clk = ~clk;

    snake_ctrl #(.MAX_LEN(MAX_LEN)) dut (
        .clk        (clk),
        .rst        (rst),
        .move_tick  (move_tick),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .food_X     (food_X),
        .food_Y     (food_Y),
        .c_pixel    (c_pixel),
        .r_pixel    (r_pixel),
        .gen_food   (gen_food),
        .game_over  (game_over),
        .snake_prnt (snake_prnt),
        .score      (score)
    );

    // ---------------------------------------------------------------- model
    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
    } cell_t;

    cell_t body[$];
    int    m_score;
    int    m_cur;
    int    m_pend;
    bit    m_eating;
    bit    m_dead;

    function automatic int opp(input int d);
        case (d)
            MU:      return MD;
            MD:      return MU;
            ML:      return MR;
            default: return ML;
        endcase
    endfunction

    function automatic cell_t next_cell(input cell_t c, input int d);
        cell_t n = c;
        case (d)
            MU:      n.y = c.y - 8'd1;
            MD:      n.y = c.y + 8'd1;
            ML:      n.x = c.x - 8'd1;
            default: n.x = c.x + 8'd1;
        endcase
        return n;
    endfunction

    function automatic bit in_area(input logic [7:0] x, input logic [7:0] y);
        return (x >= 8'h10) && (x <= 8'h90) && (y >= 8'h0A) && (y <= 8'h6E);
    endfunction

    function automatic bit model_pr(input logic [7:0] x, input logic [7:0] y);
        if (!in_area(x, y)) return 1'b0;
        foreach (body[i]) if (body[i].x == x && body[i].y == y) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        body.delete();
        body.push_back('{x: 8'h30, y: 8'h40});
        body.push_back('{x: 8'h2F, y: 8'h40});
        body.push_back('{x: 8'h2E, y: 8'h40});
        m_score  = 0;
        m_cur    = MR;
        m_pend   = MR;
        m_eating = 1'b0;
        m_dead   = 1'b0;
    endtask

    // One clock edge of the game rules, applied to the model.
    task automatic model_step(input bit tick, input logic [3:0] btn);
        cell_t nh;
        bit    hit;
        int    req;
        if (m_dead) return;
        if (m_eating) begin
            m_eating = 1'b0;
        end else if (tick) begin
            nh  = next_cell(body[0], m_pend);
            hit = !in_area(nh.x, nh.y);
            if (SELF_EN != 0) begin
                for (int i = 1; i <= int'(body.size()) - 2; i++)
                    if (body[i] == nh) hit = 1'b1;
            end
            if (hit) begin
                m_dead = 1'b1;
            end else begin
                m_cur = m_pend;
                body.push_front(nh);
                if (nh.x == food_X && nh.y == food_Y) begin
                    if (m_score < 255) m_score++;
                    m_eating = 1'b1;
                    if (body.size() > MAX_LEN) void'(body.pop_back());
                end else begin
                    void'(body.pop_back());
                end
            end
        end
        if (btn[3])      req = MU;
        else if (btn[2]) req = MD;
        else if (btn[1]) req = ML;
        else if (btn[0]) req = MR;
        else             req = -1;
        if (req >= 0 && req != opp(m_cur)) m_pend = req;
    endtask

    // ----------------------------------------------------------- scoreboard
    typedef struct packed {
        logic       gf;
        logic       go;
        logic       pr;
        logic [7:0] sc;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    total = 0;
    int    bad   = 0;

    task automatic check(input string nm, input string field,
                         input logic [7:0] got, input logic [7:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s/%s got=%0h want=%0h at %0t", nm, field, got, want, $time);
        end
    endtask

    exp_t  mon_e;
    string mon_nm;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e  = exp_q.pop_front();
            mon_nm = name_q.pop_front();
            check(mon_nm, "gen_food",   {7'd0, gen_food},   {7'd0, mon_e.gf});
            check(mon_nm, "game_over",  {7'd0, game_over},  {7'd0, mon_e.go});
            check(mon_nm, "snake_prnt", {7'd0, snake_prnt}, {7'd0, mon_e.pr});
            check(mon_nm, "score",      score,              mon_e.sc);
        end
    end

    // -------------------------------------------------------------- driver
    // Called at posedge+1. Drives this cycle's inputs, queues the outputs
    // expected before the next edge (a want_* >= 0 overrides the model with a
    // fixed value), then advances the model across that edge.
    task automatic cycle(input bit tick, input logic [3:0] btn,
                         input logic [7:0] px, input logic [7:0] py, input string name,
                         input int want_pr, input int want_sc, input int want_gf, input int want_go);
        exp_t e;
        c_pixel   = px;
        r_pixel   = py;
        move_tick = tick;
        {btn_up, btn_down, btn_left, btn_right} = btn;
        e.gf = m_eating;
        e.go = m_dead;
        e.pr = model_pr(px, py);
        e.sc = m_score[7:0];
        if (want_pr >= 0) e.pr = want_pr[0];
        if (want_sc >= 0) e.sc = want_sc[7:0];
        if (want_gf >= 0) e.gf = want_gf[0];
        if (want_go >= 0) e.go = want_go[0];
        exp_q.push_back(e);
        name_q.push_back(name);
        @(posedge clk);
        model_step(tick, btn);
        #1;
        move_tick = 1'b0;
    endtask

    task automatic probe(input logic [7:0] px, input logic [7:0] py, input string name, input int want_pr);
        cycle(1'b0, B_NONE, px, py, name, want_pr, -1, -1, -1);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        move_tick = 1'b0;
        {btn_up, btn_down, btn_left, btn_right} = B_NONE;
        @(posedge clk);
        model_reset();
        #1;
        rst = 1'b0;
    endtask

    task automatic pick_pixel(output logic [7:0] px, output logic [7:0] py);
        cell_t c;
        int    r;
        r = int'($urandom_range(0, 3));
        if (r < 2) begin
            c  = body[$urandom_range(0, body.size() - 1)];
            px = c.x;
            py = c.y;
            if (r == 1) begin
                px = c.x + 8'($urandom_range(0, 2)) - 8'd1;
                py = c.y + 8'($urandom_range(0, 2)) - 8'd1;
            end
        end else if (r == 2) begin
            px = 8'($urandom_range(16, 144));
            py = 8'($urandom_range(10, 110));
        end else begin
            px = 8'($urandom_range(0, 255));
            py = 8'($urandom_range(0, 255));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------- stimulus
    initial begin
        cell_t      nc;
        logic [7:0] px, py;
        logic [3:0] b;
        bit         tk;
        int         rdir;
        bit         turning;
        int         dead_cnt;

        rst       = 1'b1;
        move_tick = 1'b0;
        {btn_up, btn_down, btn_left, btn_right} = B_NONE;
        food_X  = 8'h00;
        food_Y  = 8'h00;
        c_pixel = 8'h00;
        r_pixel = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Reset state: three segments from (0x30,0x40) leftwards, nothing else.
        cycle(1'b0, B_NONE, 8'h30, 8'h40, "rst_head", 1, 0, 0, 0);
        probe(8'h2E, 8'h40, "rst_seg2", 1);
        probe(8'h2D, 8'h40, "rst_len3", 0);
        probe(8'h00, 8'h00, "rst_hidden", 0);

        // One move right with no buttons.
        cycle(1'b1, B_NONE, 8'h31, 8'h40, "mv_tick", 0, 0, 0, 0);
        cycle(1'b0, B_NONE, 8'h31, 8'h40, "mv_head", 1, 0, 0, 0);
        probe(8'h2F, 8'h40, "mv_seg2", 1);
        probe(8'h2E, 8'h40, "mv_tail_gone", 0);

        // Eat at (0x31,0x40): grow to 4, score 1, one gen_food pulse.
        do_reset();
        food_X = 8'h31; food_Y = 8'h40;
        cycle(1'b1, B_NONE, 8'h31, 8'h40, "eat_tick", 0, 0, 0, 0);
        food_X = 8'h00; food_Y = 8'h00;
        cycle(1'b0, B_NONE, 8'h2E, 8'h40, "eat_pulse", 1, 1, 1, 0);
        cycle(1'b0, B_NONE, 8'h31, 8'h40, "eat_back_run", 1, 1, 0, 0);
        probe(8'h2D, 8'h40, "eat_len4", 0);

        // move_tick during the gen_food cycle is dropped.
        do_reset();
        food_X = 8'h31; food_Y = 8'h40;
        cycle(1'b1, B_NONE, 8'h31, 8'h40, "eat2_tick", -1, -1, -1, -1);
        food_X = 8'h00; food_Y = 8'h00;
        cycle(1'b1, B_NONE, 8'h32, 8'h40, "eat2_tick_in_eat", 0, 1, 1, 0);
        cycle(1'b0, B_NONE, 8'h32, 8'h40, "eat2_no_move", 0, 1, 0, 0);
        probe(8'h31, 8'h40, "eat2_head_kept", 1);

        // rst while in EAT: reset values on the next cycle.
        do_reset();
        food_X = 8'h31; food_Y = 8'h40;
        cycle(1'b1, B_NONE, 8'h31, 8'h40, "eat3_tick", -1, -1, -1, -1);
        food_X = 8'h00; food_Y = 8'h00;
        do_reset();
        cycle(1'b0, B_NONE, 8'h31, 8'h40, "eat3_rst_head", 0, 0, 0, 0);
        probe(8'h2E, 8'h40, "eat3_rst_tail", 1);

        // Reversal ignored, then a turn up.
        do_reset();
        cycle(1'b0, B_LEFT, 8'h30, 8'h40, "rev_hold", -1, -1, -1, -1);
        cycle(1'b0, B_LEFT, 8'h30, 8'h40, "rev_hold", -1, -1, -1, -1);
        cycle(1'b1, B_LEFT, 8'h30, 8'h40, "rev_tick", -1, -1, -1, -1);
        cycle(1'b0, B_NONE, 8'h31, 8'h40, "rev_ignored", 1, 0, 0, 0);
        probe(8'h2E, 8'h40, "rev_tail_gone", 0);
        cycle(1'b0, B_UP, 8'h31, 8'h40, "up_press", -1, -1, -1, -1);
        cycle(1'b1, B_NONE, 8'h31, 8'h40, "up_tick", -1, -1, -1, -1);
        cycle(1'b0, B_NONE, 8'h31, 8'h3F, "up_head", 1, 0, 0, 0);

        // Run into the right wall from (0x90,0x40).
        do_reset();
        for (int k = 0; k < 8'h60; k++) begin
            pick_pixel(px, py);
            cycle(1'b1, B_NONE, px, py, "wall_run", -1, -1, -1, -1);
        end
        cycle(1'b0, B_NONE, 8'h90, 8'h40, "wall_edge", 1, 0, 0, 0);
        cycle(1'b1, B_NONE, 8'h91, 8'h40, "wall_tick", 0, 0, 0, 0);
        cycle(1'b0, B_NONE, 8'h90, 8'h40, "wall_dead", 1, 0, 0, 1);
        cycle(1'b1, B_UP, 8'h90, 8'h40, "wall_tick_ign", 1, 0, 0, 1);
        cycle(1'b1, B_DOWN, 8'h90, 8'h3F, "wall_tick_ign", 0, 0, 0, 1);
        cycle(1'b0, B_NONE, 8'h8E, 8'h40, "wall_held", 1, 0, 0, 1);
        do_reset();
        cycle(1'b0, B_NONE, 8'h30, 8'h40, "wall_rst", 1, 0, 0, 0);

        // Self-crossing: len 5, then up, left, down into the body.
        do_reset();
        food_X = 8'h31; food_Y = 8'h40;
        cycle(1'b1, B_NONE, 8'h30, 8'h40, "self_eat1", -1, -1, -1, -1);
        cycle(1'b0, B_NONE, 8'h30, 8'h40, "self_eat1p", -1, -1, -1, -1);
        food_X = 8'h32; food_Y = 8'h40;
        cycle(1'b1, B_NONE, 8'h30, 8'h40, "self_eat2", -1, -1, -1, -1);
        food_X = 8'h00; food_Y = 8'h00;
        cycle(1'b0, B_NONE, 8'h2E, 8'h40, "self_len5", 1, 2, 1, 0);
        cycle(1'b0, B_UP,   8'h32, 8'h40, "self_up", -1, -1, -1, -1);
        cycle(1'b1, B_NONE, 8'h32, 8'h40, "self_up_t", -1, -1, -1, -1);
        cycle(1'b0, B_LEFT, 8'h32, 8'h3F, "self_left", 1, 2, 0, 0);
        cycle(1'b1, B_NONE, 8'h32, 8'h3F, "self_left_t", -1, -1, -1, -1);
        cycle(1'b0, B_DOWN, 8'h31, 8'h3F, "self_down", 1, 2, 0, 0);
        cycle(1'b1, B_NONE, 8'h31, 8'h3F, "self_down_t", -1, -1, -1, -1);
        cycle(1'b0, B_NONE, 8'h31, 8'h3F, "self_result", 1, 2, 0, SELF_EN);
        probe(8'h31, 8'h40, "self_cell", 1);

        // Serpentine with food placed ahead of every move: saturates len and score.
        do_reset();
        rdir    = MR;
        turning = 1'b0;
        for (int k = 0; k < 280; k++) begin
            b = B_NONE;
            if (turning) begin
                b       = (rdir == MR) ? B_LEFT : B_RIGHT;
                rdir    = opp(rdir);
                turning = 1'b0;
            end else if ((rdir == MR && body[0].x >= 8'h80) || (rdir == ML && body[0].x <= 8'h20)) begin
                b       = B_UP;
                turning = 1'b1;
            end
            pick_pixel(px, py);
            cycle(1'b0, b, px, py, "sat_press", -1, -1, -1, -1);
            nc = next_cell(body[0], m_pend);
            food_X = nc.x; food_Y = nc.y;
            pick_pixel(px, py);
            cycle(1'b1, B_NONE, px, py, "sat_move", -1, -1, -1, -1);
            pick_pixel(px, py);
            cycle(1'b0, B_NONE, px, py, "sat_eat", -1, -1, 1, 0);
        end
        food_X = 8'h00; food_Y = 8'h00;
        pick_pixel(px, py);
        cycle(1'b0, B_NONE, px, py, "sat_score", -1, 255, 0, 0);

        // Randomised play.
        do_reset();
        dead_cnt = 0;
        for (int n = 0; n < 3000; n++) begin
            if (m_dead) dead_cnt++;
            else        dead_cnt = 0;
            if (dead_cnt > 3 || $urandom_range(0, 499) == 0) begin
                do_reset();
                dead_cnt = 0;
            end
            tk = ($urandom_range(0, 2) == 0);
            b  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : B_NONE;
            if (tk && $urandom_range(0, 2) == 0) begin
                nc = next_cell(body[0], m_pend);
                food_X = nc.x; food_Y = nc.y;
            end
            pick_pixel(px, py);
            cycle(tk, b, px, py, "rand", -1, -1, -1, -1);
        end

        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d want=0 entries left", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/snake_ctrl.md
SNAKE_CTRL -- requirements
Module: snake_ctrl

Interface
REQ-001 SHALL have parameter MAX_LEN, default 16, the maximum number of body segments including the head (range 4..32).
REQ-002 SHALL have clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-003 SHALL have rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have move_tick, input, 1 bit: one-cycle pulse that advances the snake by one cell.
REQ-005 SHALL have btn_up, btn_down, btn_left, btn_right, inputs, 1 bit each: level-sensitive direction requests.
REQ-006 SHALL have food_X and food_Y, inputs, 8 bits each: current food cell from the food generator.
REQ-007 SHALL have c_pixel and r_pixel, inputs, 8 bits each: current column and row being drawn.
REQ-008 SHALL have gen_food, output, 1 bit: one-cycle request for a new food position.
REQ-009 SHALL have game_over, output, 1 bit: sticky collision flag.
REQ-010 SHALL have snake_prnt, output, 1 bit: the current pixel is covered by a live segment.
REQ-011 SHALL have score, output, 8 bits: food eaten since reset, saturating at 0xFF.

Function
REQ-012 SHALL hold segment coordinates in a MAX_LEN-entry X/Y shift buffer, index 0 = head, with a length register len.
REQ-013 SHALL use FSM states RUN, EAT and DEAD.
REQ-014 SHALL sample the buttons every cycle into pend_dir with priority up > down > left > right; a request opposite to cur_dir SHALL be ignored.
REQ-015 SHALL, in RUN on move_tick, copy pend_dir into cur_dir, compute next head (up: Y-1, down: Y+1, left: X-1, right: X+1, 8-bit), and shift every segment i into i+1 the same cycle.
REQ-016 SHALL flag a wall hit when next head X<0x10 or X>0x90 or Y<0x0A or Y>0x6E; the state SHALL then go to DEAD with no shift, and game_over SHALL be 1 from the next cycle.
REQ-017 SHALL, when next head equals (food_X, food_Y), increment len saturating at MAX_LEN, increment score saturating at 0xFF, and enter EAT.
REQ-018 SHALL drive gen_food high for exactly one cycle in EAT, then return to RUN.
REQ-019 SHALL ignore move_tick while in EAT, with no deferral.
REQ-020 SHALL in DEAD ignore move_tick and buttons and hold all segments, len and score until rst.
REQ-021 SHALL generate snake_prnt combinationally: 1 iff some segment i < len matches (c_pixel, r_pixel); it SHALL be 0 whenever c_pixel or r_pixel is outside the play area of REQ-016.
REQ-022 SHALL give the wall hit priority over eating when both apply on the same move.
REQ-023 SHALL, when len is already MAX_LEN, still issue gen_food and increment score on eating.

Reset
REQ-024 SHALL, on rst high at a clock edge, set state=RUN, cur_dir=pend_dir=right, len=3, head=(0x30,0x40), seg1=(0x2F,0x40), seg2=(0x2E,0x40), other segments=(0x00,0x00), gen_food=0, game_over=0, score=0.
REQ-025 SHALL give rst priority over move_tick, buttons and any FSM state, including EAT and DEAD.

Configuration
REQ-026 SHALL, with SNAKE_SELF_COLLIDE_EN defined, also treat a next head equal to any segment i in 1..len-2 as a collision, handled like a wall hit.
REQ-027 SHALL, without SNAKE_SELF_COLLIDE_EN, detect wall hits only; the body may cross itself.

Verification
REQ-028 SHALL cover: reset, then one move_tick with no buttons -> head (0x31,0x40), seg2 (0x2F,0x40), len=3, gen_food=0.
REQ-029 SHALL cover: food=(0x31,0x40), one move_tick -> len=4, score=1, gen_food high exactly one cycle, then back to RUN.
REQ-030 SHALL cover: btn_left held while moving right, then move_tick -> head X increments (reversal ignored); btn_up then move_tick -> head Y=0x3F.
REQ-031 SHALL cover: head at (0x90,0x40) moving right, move_tick -> game_over=1 next cycle, head stays (0x90,0x40), later ticks no effect, rst clears it.
REQ-032 SHALL cover: move_tick asserted in the gen_food cycle -> no movement; and rst asserted during EAT -> reset values on the next cycle.
REQ-033 SHALL cover, with SNAKE_SELF_COLLIDE_EN: len=5 and the sequence up, left, down -> game_over=1; without the macro -> no game_over.
